// File: rtl/redun_to_canonical.sv
// Redundant-to-canonical converter: serial LSB-first carry propagation, one limb per beat.
// Optional parallel result port enabled by defining REDUN_CANON_PAR_OUT_EN.
module redun_to_canonical #(
    parameter  int NUM_ELEMENTS = 66,
    parameter  int DSP_BIT_LEN  = 17,
    parameter  int WORD_LEN     = 16,
    localparam int CARRY_LEN    = DSP_BIT_LEN - WORD_LEN + 1,
    localparam int IDX_W        = $clog2(NUM_ELEMENTS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_val,
    output logic                   o_rdy,
    input  logic [DSP_BIT_LEN-1:0] i_dat [NUM_ELEMENTS],
    output logic                   o_val,
    input  logic                   i_rdy,
    output logic [WORD_LEN-1:0]    o_word,
    output logic [IDX_W-1:0]       o_idx,
    output logic                   o_last,
`ifdef REDUN_CANON_PAR_OUT_EN
    output logic [WORD_LEN-1:0]    o_par [NUM_ELEMENTS],
    output logic                   o_par_val,
    output logic [CARRY_LEN-1:0]   o_carry_par,
`endif
    output logic [CARRY_LEN-1:0]   o_carry
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);

    logic [0:0]             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CARRY_LEN-1:0]   carry_q, carry_d;
    logic [DSP_BIT_LEN-1:0] buf_q [NUM_ELEMENTS];
    logic [DSP_BIT_LEN:0]   sum;
    logic                   run, is_last, accept_in, beat;

    assign run       = (state_q == ST_RUN);
    assign is_last   = (idx_q == LAST_IDX);
    assign sum       = {1'b0, buf_q[idx_q]} + (DSP_BIT_LEN + 1)'(carry_q);
    assign accept_in = i_val && o_rdy;
    assign beat      = run && i_rdy;

    assign o_rdy   = !run && !i_rst;
    assign o_val   = run;
    assign o_word  = run ? sum[WORD_LEN-1:0] : '0;
    assign o_idx   = idx_q;
    assign o_last  = run && is_last;
    assign o_carry = o_last ? sum[WORD_LEN +: CARRY_LEN] : '0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_in) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    carry_d = '0;
                end
            end
            default: begin
                if (beat) begin
                    if (is_last) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        carry_d = '0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        carry_d = sum[WORD_LEN +: CARRY_LEN];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
        end
    end

    // NOTE: the coefficient buffer has no reset; outputs are gated by state, so stale contents never leak.
    always_ff @(posedge i_clk) begin
        if (accept_in) buf_q <= i_dat;
    end

`ifdef REDUN_CANON_PAR_OUT_EN
    logic [WORD_LEN-1:0]  par_q [NUM_ELEMENTS];
    logic                 par_val_q;
    logic [CARRY_LEN-1:0] carry_par_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) par_q[i] <= '0;
            par_val_q   <= 1'b0;
            carry_par_q <= '0;
        end else begin
            par_val_q <= beat && is_last;
            if (beat) par_q[idx_q] <= o_word;
            if (beat && is_last) carry_par_q <= o_carry;
        end
    end

    assign o_par       = par_q;
    assign o_par_val   = par_val_q;
    assign o_carry_par = carry_par_q;
`endif

endmodule
